// File: rtl/adder_pkg.sv
// Shared definitions for the operand sequencer and the adder stage it feeds:
// datapath widths, latency counter width and the sequencer state encoding.
package adder_pkg;

   localparam int DATA_W = 8;
   localparam int SUM_W  = 9;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      WAIT    = 2'd2,
      PRESENT = 2'd3
   } seq_state_e;

   function automatic logic [SUM_W-1:0] pack_sum(input logic cout, input logic [DATA_W-1:0] s);
      return {cout, s};
   endfunction

endpackage

// File: rtl/operand_sequencer_if.sv
// Byte-stream input, adder-stage operand/result and result-handshake signals
// of the operand sequencer, bundled for connection to its environment.
interface operand_sequencer_if;

   logic                         in_valid;
   logic                         in_ready;
   logic [adder_pkg::DATA_W-1:0] in_data;
   logic [adder_pkg::DATA_W-1:0] A;
   logic [adder_pkg::DATA_W-1:0] B;
   logic [adder_pkg::DATA_W-1:0] S;
   logic                         Cout;
   logic                         out_valid;
   logic                         out_ready;
   logic [adder_pkg::SUM_W-1:0]  out_sum;
   logic                         busy;

   modport slave (
      input  in_valid, in_data, S, Cout, out_ready,
      output in_ready, A, B, out_valid, out_sum, busy
   );

   modport master (
      output in_valid, in_data, S, Cout, out_ready,
      input  in_ready, A, B, out_valid, out_sum, busy
   );

endinterface

// File: rtl/operand_sequencer_latency_timer.sv
// Loadable down-counter that waits out the adder-stage latency; holds at zero
// and flags terminal count so the sequencer knows when the sum is valid.
module latency_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             count,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (count && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/operand_sequencer.sv
// Collects two operand bytes, drives them to a registered adder stage, waits
// out its latency and presents the 9-bit sum under a valid/ready handshake.
//
//   state   | meaning
//   LOAD_A  | idle, waiting for operand A byte
//   LOAD_B  | A held, waiting for operand B byte
//   WAIT    | operands stable, counting down adder latency
//   PRESENT | {Cout,S} captured, out_valid high until out_ready
module operand_sequencer
   import adder_pkg::*;
#(
   parameter int LATENCY = 2
) (
   input logic                clk,
   input logic                rst_n,
   operand_sequencer_if.slave bus
);

   localparam logic [CNT_W-1:0] LAT_VAL = CNT_W'(LATENCY);

   seq_state_e        state_q;
   seq_state_e        state_d;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] a_d;
   logic [DATA_W-1:0] b_q;
   logic [DATA_W-1:0] b_d;
   logic [SUM_W-1:0]  sum_q;
   logic [SUM_W-1:0]  sum_d;
   logic              timer_load;
   logic              timer_count;
   logic              timer_zero;

   latency_timer #(
      .CNT_W (CNT_W)
   ) u_latency_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (LAT_VAL),
      .count    (timer_count),
      .zero     (timer_zero)
   );

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      timer_load  = 1'b0;
      timer_count = 1'b0;
      case (state_q)
         LOAD_A: begin
            if (bus.in_valid) begin
               a_d     = bus.in_data;
               state_d = LOAD_B;
            end
         end
         LOAD_B: begin
            if (bus.in_valid) begin
               b_d        = bus.in_data;
               timer_load = 1'b1;
               state_d    = WAIT;
            end
         end
         WAIT: begin
            timer_count = 1'b1;
            // Terminal count means the adder output reflects the held operands.
            if (timer_zero) begin
               sum_d   = pack_sum(bus.Cout, bus.S);
               state_d = PRESENT;
            end
         end
         PRESENT: begin
            if (bus.out_ready) begin
               state_d = LOAD_A;
            end
         end
         default: state_d = LOAD_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= LOAD_A;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
      end
   end

   assign bus.in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
   assign bus.out_valid = (state_q == PRESENT);
   assign bus.busy      = (state_q != LOAD_A);
   assign bus.A         = a_q;
   assign bus.B         = b_q;
   assign bus.out_sum   = sum_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: three builds (LATENCY 1, 2, 15) share
// the input stream, each paired with a registered adder stage of matching depth.
module tb_operand_sequencer;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       out_ready;
   logic [7:0] in_data;

   int total = 0;
   int bad   = 0;

   operand_sequencer_if if1 ();
   operand_sequencer_if if2 ();
   operand_sequencer_if if15 ();

   logic [8:0] pipe1  [1];
   logic [8:0] pipe2  [2];
   logic [8:0] pipe15 [15];

   assign if1.in_valid   = in_valid;
   assign if1.in_data    = in_data;
   assign if1.out_ready  = out_ready;
   assign if1.S          = pipe1[0][7:0];
   assign if1.Cout       = pipe1[0][8];

   assign if2.in_valid   = in_valid;
   assign if2.in_data    = in_data;
   assign if2.out_ready  = out_ready;
   assign if2.S          = pipe2[1][7:0];
   assign if2.Cout       = pipe2[1][8];

   assign if15.in_valid  = in_valid;
   assign if15.in_data   = in_data;
   assign if15.out_ready = out_ready;
   assign if15.S         = pipe15[14][7:0];
   assign if15.Cout      = pipe15[14][8];

   operand_sequencer #(.LATENCY(1))  u_dut_l1  (.clk(clk), .rst_n(rst_n), .bus(if1));
   operand_sequencer #(.LATENCY(2))  u_dut_l2  (.clk(clk), .rst_n(rst_n), .bus(if2));
   operand_sequencer #(.LATENCY(15)) u_dut_l15 (.clk(clk), .rst_n(rst_n), .bus(if15));

   // Adder stages: operands in, {carry,sum} out after LATENCY register stages.
   always @(posedge clk) begin
      pipe1[0]  <= {1'b0, if1.A} + {1'b0, if1.B};
      pipe2[0]  <= {1'b0, if2.A} + {1'b0, if2.B};
      pipe2[1]  <= pipe2[0];
      pipe15[0] <= {1'b0, if15.A} + {1'b0, if15.B};
      for (int i = 1; i < 15; i++) pipe15[i] <= pipe15[i-1];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         tick();
         if (if2.out_valid === 1'b1) lat = k;
      end
   endtask

   int         lat;
   int         lat1;
   int         lat2;
   int         lat15;
   int         pulses;
   logic [8:0] sum1;
   logic [8:0] sum2;
   logic [8:0] sum15;

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      #2;
      chk("rst_out_valid", if2.out_valid, 0);
      chk("rst_busy",      if2.busy,      0);
      chk("rst_out_sum",   if2.out_sum,   0);
      chk("rst_a",         if2.A,         0);
      chk("rst_b",         if2.B,         0);
      chk("rst_in_ready",  if2.in_ready,  1);
      tick();
      tick();
      rst_n = 1'b1;

      // basic add, observed on all three latency builds
      out_ready = 1'b1;
      send(8'h0F);
      chk("basic_a_capture", if2.A,        8'h0F);
      chk("basic_busy",      if2.busy,     1);
      chk("basic_ready_b",   if2.in_ready, 1);
      send(8'h01);
      chk("basic_b_capture", if2.B,        8'h01);
      chk("basic_ready_wait", if2.in_ready, 0);
      chk("basic_no_valid",  if2.out_valid, 0);
      lat1 = 0; lat2 = 0; lat15 = 0; pulses = 0;
      sum1 = '0; sum2 = '0; sum15 = '0;
      for (int k = 1; k <= 18; k++) begin
         tick();
         if (if1.out_valid === 1'b1 && lat1 == 0) begin lat1 = k; sum1 = if1.out_sum; end
         if (if2.out_valid === 1'b1 && lat2 == 0) begin lat2 = k; sum2 = if2.out_sum; end
         if (if15.out_valid === 1'b1 && lat15 == 0) begin lat15 = k; sum15 = if15.out_sum; end
         if (if2.out_valid === 1'b1) pulses++;
      end
      chk("lat_l1",        lat1,   2);
      chk("lat_l2",        lat2,   3);
      chk("lat_l15",       lat15,  16);
      chk("basic_pulses",  pulses, 1);
      chk("basic_sum_l1",  sum1,   9'h010);
      chk("basic_sum_l2",  sum2,   9'h010);
      chk("basic_sum_l15", sum15,  9'h010);
      chk("basic_a_held",  if2.A,  8'h0F);

      // carry out
      send(8'hFF);
      send(8'h01);
      wait_result(lat);
      chk("carry1_lat", lat, 3);
      chk("carry1_sum", if2.out_sum, 9'h100);
      tick();
      chk("carry1_release_valid", if2.out_valid, 0);
      chk("carry1_release_busy",  if2.busy,      0);
      send(8'hFF);
      send(8'hFF);
      wait_result(lat);
      chk("carry2_lat", lat, 3);
      chk("carry2_sum", if2.out_sum, 9'h1FE);
      tick();

      // backpressure with in_valid asserted but ignored
      out_ready = 1'b0;
      send(8'h80);
      send(8'h80);
      wait_result(lat);
      chk("bp_lat", lat, 3);
      chk("bp_sum", if2.out_sum, 9'h100);
      in_valid = 1'b1;
      in_data  = 8'h77;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_hold_valid", if2.out_valid, 1);
         chk("bp_hold_sum",   if2.out_sum,   9'h100);
         chk("bp_in_ready",   if2.in_ready,  0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("bp_release_valid", if2.out_valid, 0);
      chk("bp_release_busy",  if2.busy,      0);
      chk("bp_a_unchanged",   if2.A,         8'h80);
      chk("bp_b_unchanged",   if2.B,         8'h80);

      // reset during WAIT
      send(8'h12);
      send(8'h34);
      tick();
      chk("rw_busy_in_wait", if2.busy, 1);
      rst_n = 1'b0;
      #1;
      chk("rw_a",         if2.A,         0);
      chk("rw_b",         if2.B,         0);
      chk("rw_out_sum",   if2.out_sum,   0);
      chk("rw_out_valid", if2.out_valid, 0);
      chk("rw_busy",      if2.busy,      0);
      tick();
      rst_n = 1'b1;
      send(8'h01);
      chk("rw_first_a", if2.A, 8'h01);
      send(8'h02);
      wait_result(lat);
      chk("rw_next_lat", lat, 3);
      chk("rw_next_sum", if2.out_sum, 9'h003);
      tick();

      // back-to-back pairs separated by an idle gap
      send(8'h10);
      send(8'h20);
      wait_result(lat);
      chk("b2b_first_lat", lat, 3);
      chk("b2b_first_sum", if2.out_sum, 9'h030);
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (if2.out_valid === 1'b1) pulses++;
      end
      chk("b2b_gap_no_valid", pulses, 0);
      chk("b2b_gap_a_held",   if2.A,  8'h10);
      send(8'hAA);
      send(8'h55);
      wait_result(lat);
      chk("b2b_second_lat", lat, 3);
      chk("b2b_second_sum", if2.out_sum, 9'h0FF);
      tick();
      chk("b2b_done_valid", if2.out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 SHALL have parameter LATENCY, default 2: cycles from operands stable at the adder stage to sum valid at its output; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1: upstream byte valid.
REQ-005 SHALL have port in_ready, output, 1: sequencer accepts a byte this cycle.
REQ-006 SHALL have port in_data, input, 8: operand byte, A first, then B.
REQ-007 SHALL have port A, output, 8: operand A driven to the downstream adder stage.
REQ-008 SHALL have port B, output, 8: operand B driven to the downstream adder stage.
REQ-009 SHALL have port S, input, 8: registered sum returned from the adder stage.
REQ-010 SHALL have port Cout, input, 1: registered carry returned from the adder stage.
REQ-011 SHALL have port out_valid, output, 1: result available.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port out_sum, output, 9: captured {Cout,S}.
REQ-014 SHALL have port busy, output, 1: high whenever state is not LOAD_A.

Function
REQ-015 SHALL implement FSM states LOAD_A, LOAD_B, WAIT, PRESENT.
REQ-016 SHALL decode in_ready = 1 in LOAD_A and LOAD_B, 0 in WAIT and PRESENT.
REQ-017 SHALL, in LOAD_A, on in_valid&in_ready, register in_data into A and go to LOAD_B.
REQ-018 SHALL, in LOAD_B, on in_valid&in_ready, register in_data into B, load a 4-bit counter with LATENCY, and go to WAIT.
REQ-019 SHALL hold state and all registers in LOAD_A/LOAD_B while in_valid is low (gaps of any length allowed).
REQ-020 SHALL hold A and B stable from capture until the next LOAD_A acceptance.
REQ-021 SHALL, in WAIT, decrement the counter each cycle while it is nonzero; on the cycle it equals 0, register {Cout,S} into out_sum and go to PRESENT.
REQ-022 SHALL assert out_valid exactly LATENCY+1 cycles after the edge that accepted B (3 cycles at default).
REQ-023 SHALL assert out_valid only in PRESENT and hold out_valid and out_sum stable until out_valid&out_ready.
REQ-024 SHALL, on out_valid&out_ready, deassert out_valid next cycle and go to LOAD_A; the next pair's A byte is accepted no earlier than that next cycle.
REQ-025 SHALL produce out_sum as a 9-bit unsigned value: A+B with carry in bit 8, no truncation.
REQ-026 SHALL ignore in_valid in WAIT and PRESENT; no byte is consumed there.

Reset
REQ-027 SHALL, while rst_n is low, force state LOAD_A, A=0, B=0, counter=0, out_sum=0, out_valid=0, busy=0, independent of clk.
REQ-028 SHALL, on reset assertion mid-operation (any state), discard any partial pair or pending result; no out_valid follows for that pair.
REQ-029 SHALL accept the first A byte on the first rising edge after rst_n deasserts with in_valid high.

Structure
REQ-030 SHALL take the FSM state encoding, DATA_W=8, and SUM_W=9 from the shared package adder_pkg, used by the adder stage and this block.
REQ-031 SHALL implement the WAIT countdown as one sub-module, latency_timer (load, count, zero flag); all other logic stays flat.
REQ-032 SHALL connect to the adder stage with A/B feeding its operand inputs and S/Cout returned from its outputs; both blocks share clk.

Verification
REQ-033 SHALL cover basic add: bytes 0x0F, 0x01 with out_ready=1 -> out_sum=0x010, out_valid high 3 cycles after the B accept edge, for 1 cycle.
REQ-034 SHALL cover carry: bytes 0xFF, 0x01 -> out_sum=0x100; bytes 0xFF, 0xFF -> out_sum=0x1FE.
REQ-035 SHALL cover backpressure: 0x80, 0x80 with out_ready low 5 cycles -> out_valid and out_sum=0x100 held stable, in_ready=0 throughout, release completes in 1 cycle.
REQ-036 SHALL cover reset mid-WAIT: 0x12, 0x34, rst_n low 1 cycle in WAIT -> all outputs 0, no out_valid, and the next pair 0x01, 0x02 yields 0x003.
REQ-037 SHALL cover back-to-back pairs with in_valid gaps: (0x10, 0x20), gap of 4 cycles, then (0xAA, 0x55) -> results 0x030 then 0x0FF in order, none dropped or duplicated.
REQ-038 SHALL cover LATENCY=1 and LATENCY=15 builds: out_valid 2 and 16 cycles after the B accept edge respectively.
